// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave among N_MASTERS masters.
// A grant is held for the whole CYC burst of the winning master. One dead
// cycle separates owners. A watchdog ends stalled strobes with ERR.
module wb_rr_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_MASTERS-1:0]                     m_CYC,
  input  logic [N_MASTERS-1:0]                     m_STB,
  input  logic [N_MASTERS-1:0]                     m_WE,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]       m_ADR,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]       m_DAT_W,
  input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0]   m_SEL,
  output logic [N_MASTERS-1:0]                     m_ACK,
  output logic [N_MASTERS-1:0]                     m_ERR,
  output logic [WB_DATA_WIDTH-1:0]                 m_DAT_R,
  output logic                                     s_CYC,
  output logic                                     s_STB,
  output logic                                     s_WE,
  output logic [WB_ADDR_WIDTH-1:0]                 s_ADR,
  output logic [WB_DATA_WIDTH-1:0]                 s_DAT_W,
  output logic [WB_DATA_WIDTH/8-1:0]               s_SEL,
  input  logic                                     s_ACK,
  input  logic                                     s_ERR,
  input  logic [WB_DATA_WIDTH-1:0]                 s_DAT_R,
  output logic [N_MASTERS-1:0]                     gnt
);

  localparam int SW  = WB_DATA_WIDTH / 8;
  localparam int PW  = $clog2(N_MASTERS);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int WDW = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST  = WD_EN ? WDW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [PW-1:0]  LAST_IDX = PW'(N_MASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [PW-1:0]        gidx_q, gidx_d;   // index of the current owner
  logic [PW-1:0]        ptr_q, ptr_d;     // highest-priority master for next arbitration
  logic [WDW-1:0]       wd_cnt_q, wd_cnt_d;

  logic          busy;
  logic          raw_stb;
  logic          wd_err;
  logic          stall;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  assign busy    = (state_q == BUSY);
  assign raw_stb = busy & m_STB[gidx_q];
  assign wd_err  = WD_EN & raw_stb & (wd_cnt_q == WD_LAST);
  // The watchdog cycle hides the strobe from the slave so a late ACK cannot land.
  assign s_STB   = raw_stb & ~wd_err;
  assign stall   = WD_EN & s_STB & ~s_ACK & ~s_ERR;
  assign m_DAT_R = s_DAT_R;
  assign gnt     = gnt_q;

  // Find the first requesting master starting at ptr and wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!pick_valid && m_CYC[PW'((int'(ptr_q) + i) % N_MASTERS)]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'((int'(ptr_q) + i) % N_MASTERS);
      end
    end
  end

  // Route the owner's request to the slave and the slave's response back to the owner.
  always_comb begin
    s_CYC   = 1'b0;
    s_WE    = 1'b0;
    s_ADR   = '0;
    s_DAT_W = '0;
    s_SEL   = '0;
    m_ACK   = '0;
    m_ERR   = '0;
    if (busy) begin
      s_CYC          = m_CYC[gidx_q];
      s_WE           = m_WE[gidx_q];
      s_ADR          = m_ADR[gidx_q*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
      s_DAT_W        = m_DAT_W[gidx_q*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      s_SEL          = m_SEL[gidx_q*SW +: SW];
      m_ACK[gidx_q]  = s_ACK & s_STB;
      m_ERR[gidx_q]  = (s_ERR & s_STB) | wd_err;
    end
  end

  // Next-state: grant on request in IDLE, release on CYC drop, run the watchdog in BUSY.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    wd_cnt_d = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d         = BUSY;
          gidx_d          = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
        end
      end
      BUSY: begin
        if (!m_CYC[gidx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
        end else if (stall) begin
          wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      wd_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]  m_cyc, m_stb, m_we;
  logic [AW-1:0] adr [N];
  logic [DW-1:0] dw  [N];
  logic [SW-1:0] sel [N];
  logic [N*AW-1:0] m_adr_p;
  logic [N*DW-1:0] m_dat_p;
  logic [N*SW-1:0] m_sel_p;

  logic [N-1:0]  m_ack, m_err, gnt;
  logic [DW-1:0] m_dat_r;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w;
  logic [SW-1:0] s_sel;
  logic          s_ack, s_err;
  logic [DW-1:0] s_dat_r;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_adr_p[i*AW +: AW] = adr[i];
      m_dat_p[i*DW +: DW] = dw[i];
      m_sel_p[i*SW +: SW] = sel[i];
    end
  end

  wb_rr_arbiter #(
    .N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_CYC(m_cyc), .m_STB(m_stb), .m_WE(m_we),
    .m_ADR(m_adr_p), .m_DAT_W(m_dat_p), .m_SEL(m_sel_p),
    .m_ACK(m_ack), .m_ERR(m_err), .m_DAT_R(m_dat_r),
    .s_CYC(s_cyc), .s_STB(s_stb), .s_WE(s_we),
    .s_ADR(s_adr), .s_DAT_W(s_dat_w), .s_SEL(s_sel),
    .s_ACK(s_ack), .s_ERR(s_err), .s_DAT_R(s_dat_r),
    .gnt(gnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: current owner (-1 = none), next priority, stall count.
  int owner_m = -1;
  int ptr_m   = 0;
  int cnt_m   = 0;
  bit stb_m   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: compare every DUT output against what the model predicts.
  task automatic settle(input string tag);
    logic [63:0] e_gnt, e_cyc, e_stb, e_we, e_adr, e_dat, e_sel, e_ack, e_err;
    bit raw, wd;
    @(negedge clk);
    e_gnt = '0; e_cyc = '0; e_stb = '0; e_we = '0; e_adr = '0;
    e_dat = '0; e_sel = '0; e_ack = '0; e_err = '0;
    stb_m = 1'b0;
    if (owner_m >= 0) begin
      raw   = m_stb[owner_m];
      wd    = raw && (cnt_m == TO - 1);
      stb_m = raw && !wd;
      e_gnt = 64'd1 << owner_m;
      e_cyc = 64'(m_cyc[owner_m]);
      e_stb = 64'(stb_m);
      e_we  = 64'(m_we[owner_m]);
      e_adr = 64'(adr[owner_m]);
      e_dat = 64'(dw[owner_m]);
      e_sel = 64'(sel[owner_m]);
      if (s_ack && stb_m) e_ack = 64'd1 << owner_m;
      if ((s_err && stb_m) || wd) e_err = 64'd1 << owner_m;
    end
    check({tag, ".gnt"},     64'(gnt),     e_gnt);
    check({tag, ".s_cyc"},   64'(s_cyc),   e_cyc);
    check({tag, ".s_stb"},   64'(s_stb),   e_stb);
    check({tag, ".s_we"},    64'(s_we),    e_we);
    check({tag, ".s_adr"},   64'(s_adr),   e_adr);
    check({tag, ".s_dat_w"}, 64'(s_dat_w), e_dat);
    check({tag, ".s_sel"},   64'(s_sel),   e_sel);
    check({tag, ".m_ack"},   64'(m_ack),   e_ack);
    check({tag, ".m_err"},   64'(m_err),   e_err);
    check({tag, ".m_dat_r"}, 64'(m_dat_r), 64'(s_dat_r));
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic advance();
    if (rst) begin
      owner_m = -1; ptr_m = 0; cnt_m = 0;
    end else if (owner_m < 0) begin
      cnt_m = 0;
      for (int i = 0; i < N; i++) begin
        if (owner_m < 0 && m_cyc[(ptr_m + i) % N]) owner_m = (ptr_m + i) % N;
      end
    end else if (!m_cyc[owner_m]) begin
      ptr_m   = (owner_m + 1) % N;
      owner_m = -1;
      cnt_m   = 0;
    end else begin
      cnt_m = (stb_m && !s_ack && !s_err) ? cnt_m + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    settle(tag);
    advance();
  endtask

  initial begin
    int order_n;
    int dead;
    int acks;
    logic [N-1:0] prev_gnt;
    logic [N-1:0] drop;
    logic [DW-1:0] vals [4];
    bit dead_slave;

    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst = 1'b1;
    m_cyc = 2'b11; m_stb = '0; m_we = '0;
    for (int i = 0; i < N; i++) begin adr[i] = '0; dw[i] = '0; sel[i] = '0; end
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
    #3;

    // Reset holds everything idle even with both masters requesting.
    step("reset");
    settle("reset2");
    check("reset.gnt",   64'(gnt),   64'd0);
    check("reset.s_cyc", 64'(s_cyc), 64'd0);
    check("reset.m_ack", 64'(m_ack), 64'd0);
    advance();
    rst = 1'b0;
    step("rst_rel");
    settle("grant0");
    check("grant0.gnt", 64'(gnt), 64'h1);
    advance();
    m_cyc = '0;
    step("rel0");
    step("idle0");

    // Single master write from master1.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    adr[1] = 32'h100; dw[1] = 32'hDEADBEEF; sel[1] = 4'hF;
    step("sm.arb");
    step("sm.wait1");
    step("sm.wait2");
    s_ack = 1'b1;
    settle("sm.ack");
    check("sm.s_adr", 64'(s_adr),   64'h100);
    check("sm.dat",   64'(s_dat_w), 64'hDEADBEEF);
    check("sm.m_ack", 64'(m_ack),   64'h2);
    advance();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    step("sm.rel");
    step("sm.idle");

    // Round-robin: each master does one transfer per tenure, then re-requests.
    adr[0] = 32'h200; adr[1] = 32'h300;
    m_cyc = '1; m_stb = '1; s_ack = 1'b1;
    order_n = 0; dead = 0; prev_gnt = '0;
    for (int c = 0; c < 60 && order_n < 6; c++) begin
      settle("rr");
      if (gnt != '0 && prev_gnt == '0) begin
        check("rr.order", 64'(gnt[1] ? 1 : 0), 64'(order_n % 2));
        if (order_n > 0) check("rr.dead", 64'(dead), 64'd1);
        order_n++;
        dead = 0;
      end
      if (gnt == '0) dead++;
      prev_gnt = gnt;
      drop = m_ack;
      advance();
      m_cyc = ~drop;
      m_stb = ~drop;
    end
    check("rr.tenures", 64'(order_n), 64'd6);
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    repeat (3) step("rr.drain");

    // Burst hold: master0 keeps CYC over 4 reads while master1 waits.
    m_cyc = 2'b11; m_stb = 2'b01; m_we = '0;
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      s_ack   = (c % 2 == 1);
      s_dat_r = vals[acks];
      settle("burst");
      check("burst.no_m1", 64'(gnt[1]), 64'd0);
      if (m_ack[0]) begin
        check("burst.dat", 64'(m_dat_r), 64'(vals[acks]));
        acks++;
      end
      advance();
    end
    check("burst.count", 64'(acks), 64'd4);
    m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'b0;
    step("burst.rel");
    step("burst.idle");

    // Watchdog: slave never answers; ERR on the 8th stalled cycle, late ACK masked.
    for (int k = 1; k <= TO; k++) begin
      if (k == TO) s_ack = 1'b1;
      settle("wd");
      if (k == 1) check("wd.gnt", 64'(gnt), 64'h2);
      if (k < TO) begin
        check("wd.no_err", 64'(m_err), 64'd0);
        check("wd.stb",    64'(s_stb), 64'd1);
      end else begin
        check("wd.err",    64'(m_err), 64'h2);
        check("wd.stb_lo", 64'(s_stb), 64'd0);
        check("wd.ack_lo", 64'(m_ack), 64'd0);
      end
      advance();
    end
    s_ack = 1'b0; m_cyc = 2'b01; m_stb = '0;
    step("wd.rel");
    step("wd.idle");
    settle("wd.next");
    check("wd.next_gnt", 64'(gnt), 64'h1);
    advance();

    // Async reset during master1's tenure.
    m_cyc = 2'b10; m_stb = 2'b10;
    step("ar.rel0");
    step("ar.idle");
    settle("ar.busy");
    check("ar.busy_gnt", 64'(gnt),   64'h2);
    check("ar.busy_cyc", 64'(s_cyc), 64'd1);
    advance();
    #2;
    rst = 1'b1;
    #1;
    check("ar.gnt",   64'(gnt),   64'd0);
    check("ar.s_cyc", 64'(s_cyc), 64'd0);
    owner_m = -1; ptr_m = 0; cnt_m = 0;
    step("ar.hold");
    rst = 1'b0;
    m_cyc = 2'b11;
    step("ar.rel");
    settle("ar.regrant");
    check("ar.regrant_gnt", 64'(gnt), 64'h1);
    advance();

    // Randomized traffic with periodic dead-slave stretches.
    dead_slave = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) dead_slave = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i] = 1'($urandom_range(0, 3) != 0);
        m_we[i]  = 1'($urandom_range(0, 1));
        adr[i]   = $urandom;
        dw[i]    = $urandom;
        sel[i]   = 4'($urandom);
      end
      s_ack   = dead_slave ? 1'b0 : ($urandom_range(0, 2) == 0);
      s_err   = ($urandom_range(0, 30) == 0);
      s_dat_r = $urandom;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
